// File: rtl/unit_prop_ctrl_pkg.sv
// unit_prop_ctrl_pkg: formula types, widths and controller state encoding shared by the unit-propagation slice
package unit_prop_ctrl_pkg;
    localparam int VAR_W       = 3;
    localparam int MAX_LITS    = 3;
    localparam int MAX_CLAUSES = 12;
    localparam int LC_W        = $clog2(MAX_LITS + 1);
    localparam int CC_W        = $clog2(MAX_CLAUSES + 1);
    localparam int IDX_W       = $clog2(MAX_CLAUSES);

    typedef struct packed {
        logic [VAR_W-1:0] id;
        logic             pol;
    } lit;

    typedef struct packed {
        logic [LC_W-1:0]   count;
        lit [MAX_LITS-1:0] lits;
    } clause;

    typedef struct packed {
        logic [CC_W-1:0]         count;
        clause [MAX_CLAUSES-1:0] clauses;
    } formula;

    localparam lit zero_lit = '0;

    typedef enum logic [2:0] {
        PC_IDLE,
        PC_SCAN,
        PC_ISSUE,
        PC_WAIT,
        PC_FIN
    } pc_state_t;
endpackage

// File: rtl/unit_prop_ctrl_unit_scan.sv
// unit_prop_ctrl_unit_scan: classifies one clause as empty or unit and exposes its first literal
module unit_prop_ctrl_unit_scan
    import unit_prop_ctrl_pkg::*;
(
    input  clause clause_i,
    output logic  unit_o,
    output logic  empty_o,
    output lit    lit0_o
);
    assign unit_o  = clause_i.count == LC_W'(1);
    assign empty_o = clause_i.count == '0;
    assign lit0_o  = clause_i.lits[0];
endmodule

// File: rtl/unit_prop_ctrl.sv
// unit_prop_ctrl: repeatedly finds a unit clause, propagates its literal and records the implied trail
module unit_prop_ctrl
    import unit_prop_ctrl_pkg::*;
#(
    parameter int MAX_UNITS = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  formula                       in_formula,
    output logic                         pl_find,
    output lit                           pl_lit,
    output formula                       pl_formula,
    input  logic                         pl_ended,
    input  logic                         pl_empty_clause,
    input  logic                         pl_empty_formula,
    input  formula                       pl_out_formula,
    output logic                         done,
    output logic                         busy,
    output logic                         conflict,
    output logic                         sat,
    output formula                       out_formula,
    output lit                           trail [MAX_UNITS],
    output logic [$clog2(MAX_UNITS+1)-1:0] trail_count
);
    localparam int CNT_W = $clog2(MAX_UNITS + 1);
    localparam int TI_W  = MAX_UNITS > 1 ? $clog2(MAX_UNITS) : 1;

    pc_state_t        state_q, state_d;
    formula           wf_q, wf_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    lit               lit_q, lit_d;
    lit               trail_q [MAX_UNITS];
    lit               trail_d [MAX_UNITS];
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             conflict_q, conflict_d;
    logic             sat_q, sat_d;

    logic             cl_unit, cl_empty;
    lit               cl_lit0;
    logic [CC_W-1:0]  eff_count;
    logic             at_last;

    unit_prop_ctrl_unit_scan u_scan (
        .clause_i (wf_q.clauses[idx_q]),
        .unit_o   (cl_unit),
        .empty_o  (cl_empty),
        .lit0_o   (cl_lit0)
    );

    // clause counts above the storage depth are clamped so the scan never indexes past the array
    assign eff_count = wf_q.count > CC_W'(MAX_CLAUSES) ? CC_W'(MAX_CLAUSES) : wf_q.count;
    assign at_last   = CC_W'(idx_q) == eff_count - CC_W'(1);

    assign pl_lit      = lit_q;
    assign pl_formula  = wf_q;
    assign out_formula = wf_q;
    assign trail       = trail_q;
    assign trail_count = tcnt_q;
    assign conflict    = conflict_q;
    assign sat         = sat_q;

    // next-state and strobe outputs: scan for a unit, hand it off, fold the reduced formula back in
    always_comb begin
        state_d    = state_q;
        wf_d       = wf_q;
        idx_d      = idx_q;
        lit_d      = lit_q;
        trail_d    = trail_q;
        tcnt_d     = tcnt_q;
        conflict_d = conflict_q;
        sat_d      = sat_q;
        pl_find    = 1'b0;
        done       = 1'b0;
        busy       = state_q != PC_IDLE;
        case (state_q)
            PC_IDLE: begin
                if (start) begin
                    wf_d       = in_formula;
                    tcnt_d     = '0;
                    conflict_d = 1'b0;
                    sat_d      = 1'b0;
                    idx_d      = '0;
                    state_d    = PC_SCAN;
                end
            end
            PC_SCAN: begin
                if (wf_q.count == '0) begin
                    sat_d   = 1'b1;
                    state_d = PC_FIN;
                end else if (cl_empty) begin
                    conflict_d = 1'b1;
                    state_d    = PC_FIN;
                end else if (cl_unit) begin
                    lit_d   = cl_lit0;
                    state_d = PC_ISSUE;
                end else if (at_last) begin
                    state_d = PC_FIN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            PC_ISSUE: begin
                pl_find = 1'b1;
                state_d = PC_WAIT;
            end
            PC_WAIT: begin
                if (pl_ended) begin
                    trail_d[tcnt_q[TI_W-1:0]] = lit_q;
                    tcnt_d = tcnt_q + CNT_W'(1);
                    wf_d   = pl_out_formula;
                    if (pl_empty_clause) begin
                        conflict_d = 1'b1;
                        state_d    = PC_FIN;
                    end else if (pl_empty_formula) begin
                        sat_d   = 1'b1;
                        state_d = PC_FIN;
                    end else if (tcnt_d == CNT_W'(MAX_UNITS)) begin
                        state_d = PC_FIN;
                    end else begin
                        idx_d   = '0;
                        state_d = PC_SCAN;
                    end
                end
            end
            PC_FIN: begin
                done    = 1'b1;
                state_d = PC_IDLE;
            end
            default: state_d = PC_IDLE;
        endcase
    end

    // state register; reset returns to idle at once, which also drops pl_find
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= PC_IDLE;
            wf_q       <= '0;
            idx_q      <= '0;
            lit_q      <= zero_lit;
            trail_q    <= '{default: zero_lit};
            tcnt_q     <= '0;
            conflict_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wf_q       <= wf_d;
            idx_q      <= idx_d;
            lit_q      <= lit_d;
            trail_q    <= trail_d;
            tcnt_q     <= tcnt_d;
            conflict_q <= conflict_d;
            sat_q      <= sat_d;
        end
    end
endmodule
